if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the pipelined MIPS CPU: it holds the program counter, drives the combinational instruction memory address, selects the next PC, and registers the fetched word into the IF/ID pipeline register. It sits between the hazard/branch logic in ID/EX, which supplies stall, flush and redirect requests, and the decode stage, which consumes `id_inst` and `id_pc_plus4`.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `NOP_INST`, 32'h0000_0000, word inserted into IF/ID on reset and flush
- `clk`  in  1  single system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `stall`  in  1  load-use hazard: hold PC and IF/ID
- `ex_branch_taken`  in  1  branch resolved taken in EX
- `ex_branch_target`  in  32  branch target from EX
- `id_jump`  in  1  j/jal/jr/jalr decoded in ID
- `id_jump_target`  in  32  jump target from ID (register value for jr/jalr)
- `imem_addr`  out  32  current PC to instruction memory (combinational from PC reg)
- `imem_inst`  in  32  instruction word returned by memory, same cycle
- `id_inst`  out  32  IF/ID instruction
- `id_pc_plus4`  out  32  IF/ID PC+4 (link value, branch base)
- `id_valid`  out  1  IF/ID holds a real fetched instruction

## Operation
- `pc` register; `imem_addr = pc`; `pc_plus4 = pc + 4`, 32-bit, wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- Next-PC priority, highest first:
  - `reset`: `RESET_PC`.
  - `ex_branch_taken`: `ex_branch_target`. Overrides `stall` and `id_jump`; the branch is older than both.
  - `id_jump` and not `stall`: `id_jump_target`.
  - `stall`: hold `pc`.
  - Otherwise: `pc_plus4`.
- Redirect targets load with bits [1:0] forced to 2'b00.
- IF/ID update, same priority:
  - `reset`: `id_inst=NOP_INST`, `id_pc_plus4=0`, `id_valid=0`.
  - `ex_branch_taken`: load NOP, `id_valid=0`. This flushes the wrong-path instruction; `id_pc_plus4` is also set to 0.
  - `id_jump` and not `stall`: load NOP, `id_valid=0`. No delay slot; the word fetched behind the jump is squashed.
  - `stall`: hold all IF/ID fields.
  - Otherwise: `id_inst=imem_inst`, `id_pc_plus4=pc_plus4`, `id_valid=1`.
- `id_jump` with `stall` asserted: the jump is ignored this cycle. The jump is re-presented because the ID stage is held.
- No internal state beyond `pc` and the three IF/ID fields.

## Timing
- Reset values: `pc=RESET_PC`, so `imem_addr=RESET_PC` in the cycle after the reset edge. `id_inst=NOP_INST`, `id_pc_plus4=0`, `id_valid=0`.
- Fetch latency: PC P at cycle N. Its word appears on `id_inst` in cycle N+1, with `id_pc_plus4=P+4`.
- Redirect penalty:
  - Taken branch: 2 bubbles (ID and IF squashed). Only IF/ID is squashed here; squashing ID/EX belongs to the hazard unit.
  - Jump: 1 bubble.
- Reset asserted mid-stream: the next edge restores all reset values regardless of other inputs. Fetch restarts at `RESET_PC` the cycle after `reset` falls.
- All inputs are sampled only at the rising edge. `imem_addr` changes only after the edge.

## Test plan
- Reset then free-run, memory returning 32'h20090001 at 0 and 32'h200a0002 at 4:
  - `imem_addr` sequence 0, 4, 8.
  - `id_inst`/`id_pc_plus4` = NOP/0, then 32'h20090001/4, then 32'h200a0002/8.
  - `id_valid` 0, 1, 1.
- `stall` held 2 cycles while PC=8:
  - `imem_addr` stays 8.
  - IF/ID holds the word from 4.
  - Fetch resumes at 12 after release.
- `id_jump=1`, target 32'h18, while PC=12:
  - Next `imem_addr` = 32'h18.
  - `id_inst` = NOP, `id_valid=0` for one cycle.
  - Then the word from 32'h18 appears with `id_pc_plus4` = 32'h1C.
- `ex_branch_taken=1`, target 32'h3A, with `stall=1` and `id_jump=1`, target 32'h40:
  - Next PC = 32'h38 (low bits cleared, branch wins).
  - IF/ID = NOP, `id_valid=0`.
- PC = 32'hFFFF_FFFC, no redirect: next `imem_addr` = 32'h0000_0000 and `id_pc_plus4` = 0.
- `reset` pulsed one cycle mid-run with `stall=1`: all outputs return to reset values and `imem_addr` = `RESET_PC` on the following cycle.

Source files
------------

// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// if_stage_if
// Bundles the fetch-stage signals that cross between the IF stage and its
// neighbours: hazard/branch requests from ID/EX, the combinational
// instruction-memory port, and the IF/ID pipeline register outputs.
//
// Signals
//   stall             load-use hazard, hold PC and IF/ID
//   ex_branch_taken   branch resolved taken in EX
//   ex_branch_target  branch target from EX
//   id_jump           j/jal/jr/jalr decoded in ID
//   id_jump_target    jump target from ID
//   imem_addr         current PC to instruction memory
//   imem_inst         instruction word returned in the same cycle
//   id_inst           IF/ID instruction
//   id_pc_plus4       IF/ID PC+4
//   id_valid          IF/ID holds a real fetched instruction
//
// Modports
//   master  the fetch stage itself (drives imem_addr and IF/ID)
//   slave   the surrounding pipeline and memory
// ---------------------------------------------------------------------------
interface if_stage_if;
    logic        stall;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        id_jump;
    logic [31:0] id_jump_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic [31:0] id_inst;
    logic [31:0] id_pc_plus4;
    logic        id_valid;

    modport master (
        input  stall,
        input  ex_branch_taken,
        input  ex_branch_target,
        input  id_jump,
        input  id_jump_target,
        input  imem_inst,
        output imem_addr,
        output id_inst,
        output id_pc_plus4,
        output id_valid
    );

    modport slave (
        output stall,
        output ex_branch_taken,
        output ex_branch_target,
        output id_jump,
        output id_jump_target,
        output imem_inst,
        input  imem_addr,
        input  id_inst,
        input  id_pc_plus4,
        input  id_valid
    );
endinterface

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage of the pipelined MIPS CPU. Holds the PC, presents
// it to the instruction memory, picks the next PC from reset / taken branch /
// jump / stall / sequential, and registers the fetched word into IF/ID.
//
// Ports
//   clk    system clock, all updates on the rising edge
//   reset  synchronous, active-high
//   bus    if_stage_if.master (hazard requests, imem port, IF/ID outputs)
//
// Parameters
//   RESET_PC  PC loaded on reset
//   NOP_INST  word placed in IF/ID on reset and on squash
//
// Redirect priority, highest first:
//   reset | ex_branch_taken | id_jump & !stall | stall | sequential
// A taken branch beats stall and jump because it is the oldest instruction
// in flight. A jump under stall is simply ignored; ID is held, so the jump
// is presented again once the stall drops.
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    if_stage_if.master  bus
);

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_HOLD   = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_BRANCH = 2'd3
    } pc_sel_e;

    logic [31:0] pc_q,          pc_d;
    logic [31:0] id_inst_q,     id_inst_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic        id_valid_q,    id_valid_d;

    logic [31:0] pc_plus4;
    pc_sel_e     pc_sel;

    // 32-bit add, so 32'hFFFF_FFFC naturally wraps to 0.
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_sel = SEL_SEQ;
        if (bus.ex_branch_taken) begin
            pc_sel = SEL_BRANCH;
        end else if (bus.id_jump && !bus.stall) begin
            pc_sel = SEL_JUMP;
        end else if (bus.stall) begin
            pc_sel = SEL_HOLD;
        end
    end

    always_comb begin
        pc_d          = pc_plus4;
        id_inst_d     = bus.imem_inst;
        id_pc_plus4_d = pc_plus4;
        id_valid_d    = 1'b1;
        unique case (pc_sel)
            SEL_BRANCH: begin
                // Redirect targets are word aligned; low bits are dropped.
                pc_d          = {bus.ex_branch_target[31:2], 2'b00};
                id_inst_d     = NOP_INST;
                id_pc_plus4_d = 32'd0;
                id_valid_d    = 1'b0;
            end
            SEL_JUMP: begin
                // No delay slot: the word fetched behind the jump is squashed.
                pc_d          = {bus.id_jump_target[31:2], 2'b00};
                id_inst_d     = NOP_INST;
                id_pc_plus4_d = 32'd0;
                id_valid_d    = 1'b0;
            end
            SEL_HOLD: begin
                pc_d          = pc_q;
                id_inst_d     = id_inst_q;
                id_pc_plus4_d = id_pc_plus4_q;
                id_valid_d    = id_valid_q;
            end
            default: begin
                pc_d          = pc_plus4;
                id_inst_d     = bus.imem_inst;
                id_pc_plus4_d = pc_plus4;
                id_valid_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            id_inst_q     <= NOP_INST;
            id_pc_plus4_q <= 32'd0;
            id_valid_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            id_inst_q     <= id_inst_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            id_valid_q    <= id_valid_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.id_inst     = id_inst_q;
    assign bus.id_pc_plus4 = id_pc_plus4_q;
    assign bus.id_valid    = id_valid_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic clk = 1'b0;
    logic reset;

    if_stage_if bus ();

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory: two fixed words at 0 and 4, address-derived elsewhere.
    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem = 32'h2009_0001;
            32'h0000_0004: mem = 32'h200a_0002;
            default:       mem = 32'hC000_0000 ^ a;
        endcase
    endfunction

    assign bus.imem_inst = mem(bus.imem_addr);

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] br_t;
        logic        jmp;
        logic [31:0] jmp_t;
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        valid;
        logic        chk_pc4;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic stall, input logic br,
                                input logic [31:0] br_t, input logic jmp, input logic [31:0] jmp_t,
                                input logic [31:0] addr, input logic [31:0] inst,
                                input logic [31:0] pc4, input logic valid, input logic chk_pc4);
        vec_t v;
        v.rst = rst; v.stall = stall; v.br = br; v.br_t = br_t; v.jmp = jmp; v.jmp_t = jmp_t;
        v.addr = addr; v.inst = inst; v.pc4 = pc4; v.valid = valid; v.chk_pc4 = chk_pc4;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic stall, input logic br, input logic [31:0] br_t,
                         input logic jmp, input logic [31:0] jmp_t);
        reset                = rst;
        bus.stall            = stall;
        bus.ex_branch_taken  = br;
        bus.ex_branch_target = br_t;
        bus.id_jump          = jmp;
        bus.id_jump_target   = jmp_t;
    endtask

    // Reference model state (spec-level: PC and the IF/ID contents).
    logic [31:0] m_pc, m_inst, m_pc4;
    logic        m_valid;

    task automatic model_step(input logic rst, input logic stall, input logic br, input logic [31:0] br_t,
                              input logic jmp, input logic [31:0] jmp_t);
        logic [31:0] fetched;
        fetched = mem(m_pc);
        if (rst) begin
            m_pc = 0; m_inst = 0; m_pc4 = 0; m_valid = 0;
        end else if (br) begin
            m_pc = br_t & ~32'd3; m_inst = 0; m_pc4 = 0; m_valid = 0;
        end else if (jmp && !stall) begin
            m_pc = jmp_t & ~32'd3; m_inst = 0; m_pc4 = 0; m_valid = 0;
        end else if (!stall) begin
            m_inst = fetched; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
        end
    endtask

    initial begin
        // rst stall br br_t jmp jmp_t | addr inst pc4 valid chk_pc4
        tbl.push_back(mk(1,0,0,0,0,0,            32'h0,  32'h0,         32'h0,  0, 1)); // reset
        tbl.push_back(mk(0,0,0,0,0,0,            32'h4,  32'h2009_0001, 32'h4,  1, 1));
        tbl.push_back(mk(0,0,0,0,0,0,            32'h8,  32'h200a_0002, 32'h8,  1, 1));
        tbl.push_back(mk(0,1,0,0,0,0,            32'h8,  32'h200a_0002, 32'h8,  1, 1)); // stall
        tbl.push_back(mk(0,1,0,0,0,0,            32'h8,  32'h200a_0002, 32'h8,  1, 1));
        tbl.push_back(mk(0,0,0,0,0,0,            32'hC,  32'hC000_0008, 32'hC,  1, 1)); // resume
        tbl.push_back(mk(0,0,0,0,1,32'h18,       32'h18, 32'h0,         32'h0,  0, 0)); // jump
        tbl.push_back(mk(0,0,0,0,0,0,            32'h1C, 32'hC000_0018, 32'h1C, 1, 1));
        tbl.push_back(mk(0,1,1,32'h3A,1,32'h40,  32'h38, 32'h0,         32'h0,  0, 1)); // branch wins
        tbl.push_back(mk(0,0,0,0,0,0,            32'h3C, 32'hC000_0038, 32'h3C, 1, 1));
        tbl.push_back(mk(0,1,0,0,1,32'h80,       32'h3C, 32'hC000_0038, 32'h3C, 1, 1)); // jump under stall
        tbl.push_back(mk(0,0,0,0,1,32'h80,       32'h80, 32'h0,         32'h0,  0, 0)); // re-presented
        tbl.push_back(mk(0,0,1,32'hFFFF_FFFF,0,0,32'hFFFF_FFFC, 32'h0,  32'h0,  0, 1)); // to top
        tbl.push_back(mk(0,0,0,0,0,0,            32'h0,  32'h3FFF_FFFC, 32'h0,  1, 1)); // wrap
        tbl.push_back(mk(0,0,0,0,0,0,            32'h4,  32'h2009_0001, 32'h4,  1, 1));
        tbl.push_back(mk(1,1,0,0,0,0,            32'h0,  32'h0,         32'h0,  0, 1)); // reset+stall
        tbl.push_back(mk(0,0,0,0,0,0,            32'h4,  32'h2009_0001, 32'h4,  1, 1));
        tbl.push_back(mk(1,0,1,32'h100,1,32'h200,32'h0,  32'h0,         32'h0,  0, 1)); // reset+br
        tbl.push_back(mk(0,0,0,0,0,0,            32'h4,  32'h2009_0001, 32'h4,  1, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].br, tbl[i].br_t, tbl[i].jmp, tbl[i].jmp_t);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d imem_addr", i), bus.imem_addr, tbl[i].addr);
            chk($sformatf("vec%0d id_inst", i),   bus.id_inst,   tbl[i].inst);
            chk($sformatf("vec%0d id_valid", i),  {31'd0, bus.id_valid}, {31'd0, tbl[i].valid});
            if (tbl[i].chk_pc4)
                chk($sformatf("vec%0d id_pc_plus4", i), bus.id_pc_plus4, tbl[i].pc4);
            @(negedge clk);
        end

        // Randomized run against the reference model; first cycle is a reset.
        for (int c = 0; c < 600; c++) begin
            logic r, s, b, j;
            logic [31:0] bt, jt;
            r  = (c == 0) || ($urandom_range(0, 49) == 0);
            s  = ($urandom_range(0, 4) == 0);
            b  = ($urandom_range(0, 7) == 0);
            j  = ($urandom_range(0, 7) == 0);
            bt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            jt = $urandom;
            drive(r, s, b, bt, j, jt);
            model_step(r, s, b, bt, j, jt);
            @(posedge clk);
            #1;
            chk("rnd imem_addr",   bus.imem_addr,   m_pc);
            chk("rnd id_inst",     bus.id_inst,     m_inst);
            chk("rnd id_pc_plus4", bus.id_pc_plus4, m_pc4);
            chk("rnd id_valid",    {31'd0, bus.id_valid}, {31'd0, m_valid});
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
